// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the debug trace buffer: entry field widths, the
// full-buffer policy encodings, the stored entry layout and a saturating
// adder for the lost-event counter.
// Optional build macro: TRACE_TIMESTAMP_EN adds a 32-bit timestamp field to
// each stored entry.
// ---------------------------------------------------------------------------
package trace_pkg;

    localparam int PC_W   = 32;
    localparam int WNUM_W = 5;
    localparam int DATA_W = 32;
    localparam int TS_W   = 32;

    // Full-buffer policy selected by the MODE parameter
    localparam int MODE_DROP      = 0;  // reject new events when full
    localparam int MODE_OVERWRITE = 1;  // evict oldest entries to make room

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [WNUM_W-1:0] wnum;
        logic [DATA_W-1:0] wdata;
        logic              lane;
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
    } trace_entry_t;

    // 16-bit add that sticks at 0xFFFF instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                              input logic [1:0]  inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/trace_lane_qualify.sv
// ---------------------------------------------------------------------------
// trace_lane_qualify
// Decides whether one writeback lane carries a traceable event: at least one
// byte enable set and a destination other than the hard-wired zero register.
// Ports:
//   i_wen   in  4  register-file byte write enables
//   i_wnum  in  5  destination register number
//   o_qual  out 1  lane event is to be traced
// ---------------------------------------------------------------------------
module trace_lane_qualify
    import trace_pkg::*;
(
    input  logic [3:0]        i_wen,
    input  logic [WNUM_W-1:0] i_wnum,
    output logic              o_qual
);

    assign o_qual = (i_wen != 4'd0) && (i_wnum != '0);

endmodule

// File: rtl/debug_trace_buffer.sv
// ---------------------------------------------------------------------------
// debug_trace_buffer
// Captures qualified register writeback events from up to two commit lanes
// into a circular buffer and presents the oldest entry to a consumer with a
// valid/ready handshake. When the buffer is full, new events are either
// dropped (MODE 0) or overwrite the oldest entries (MODE 1); every lost event
// is counted in a saturating 16-bit counter.
// Optional build macro: TRACE_TIMESTAMP_EN adds a free-running cycle counter
// stamped into each entry and the out_ts output.
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous active-low reset
//   in_pc      in   LANES*32   per-lane writeback PC
//   in_wen     in   LANES*4    per-lane byte write enables
//   in_wnum    in   LANES*5    per-lane destination register
//   in_wdata   in   LANES*32   per-lane write data
//   out_valid  out  1          head entry available
//   out_ready  in   1          consumer accepts head entry
//   out_pc     out  32         head entry PC
//   out_wnum   out  5          head entry destination register
//   out_wdata  out  32         head entry write data
//   out_lane   out  1          lane the head entry came from
//   out_ts     out  32         head entry timestamp (TRACE_TIMESTAMP_EN only)
//   count      out  clog2+1    current occupancy
//   drop_cnt   out  16         lost-event counter, saturating
// ---------------------------------------------------------------------------
module debug_trace_buffer
    import trace_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int MODE  = 0
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*PC_W-1:0]   in_pc,
    input  logic [LANES*4-1:0]      in_wen,
    input  logic [LANES*WNUM_W-1:0] in_wnum,
    input  logic [LANES*DATA_W-1:0] in_wdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [WNUM_W-1:0]       out_wnum,
    output logic [DATA_W-1:0]       out_wdata,
    output logic                    out_lane,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]         out_ts,
`endif
    output logic [$clog2(DEPTH):0]  count,
    output logic [15:0]             drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [15:0]    r_drop_cnt;
    trace_entry_t   r_mem [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
`endif

    logic           w_qual  [LANES];
    trace_entry_t   w_entry [LANES];
    logic           w_acc   [LANES];
    logic [AW-1:0]  w_off   [LANES];
    logic           w_pop;
    logic [CW-1:0]  w_free;
    logic [CW-1:0]  w_nq;
    logic [CW-1:0]  w_nacc;
    logic [CW-1:0]  w_ovw;
    logic [CW-1:0]  w_drop_inc;
    trace_entry_t   w_head;

    // Per-lane qualification and entry assembly
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        trace_lane_qualify u_qual (
            .i_wen  (in_wen[4*k +: 4]),
            .i_wnum (in_wnum[WNUM_W*k +: WNUM_W]),
            .o_qual (w_qual[k])
        );

        always_comb begin
            w_entry[k]       = '0;
            w_entry[k].pc    = in_pc[PC_W*k +: PC_W];
            w_entry[k].wnum  = in_wnum[WNUM_W*k +: WNUM_W];
            w_entry[k].wdata = in_wdata[DATA_W*k +: DATA_W];
            w_entry[k].lane  = 1'(k);
`ifdef TRACE_TIMESTAMP_EN
            // Every lane of one cycle carries the same stamp
            w_entry[k].ts    = r_ts;
`endif
        end
    end

    // Push/pop arbitration. A pop in the same cycle frees a slot that the
    // pushes of that cycle may use. Accepted events are packed into
    // consecutive slots in lane order; in drop mode a lane is refused only
    // once no free slot remains, so later lanes never overtake earlier ones.
    always_comb begin
        logic [CW-1:0] v_nq;
        logic [CW-1:0] v_nacc;
        w_pop  = (r_count != '0) && out_ready;
        w_free = CW'(DEPTH) - r_count + CW'(w_pop);
        v_nq   = '0;
        v_nacc = '0;
        for (int k = 0; k < LANES; k++) begin
            w_acc[k] = 1'b0;
            w_off[k] = '0;
            if (w_qual[k]) begin
                v_nq = v_nq + 1'b1;
                if (MODE == MODE_OVERWRITE || v_nacc < w_free) begin
                    w_acc[k] = 1'b1;
                    w_off[k] = v_nacc[AW-1:0];
                    v_nacc   = v_nacc + 1'b1;
                end
            end
        end
        w_nq   = v_nq;
        w_nacc = v_nacc;
        // Overwrite mode evicts as many oldest entries as pushes exceed room
        w_ovw  = (MODE == MODE_OVERWRITE && w_nacc > w_free) ? (w_nacc - w_free) : '0;
        w_drop_inc = (MODE == MODE_OVERWRITE) ? w_ovw : (w_nq - w_nacc);
    end

    // Control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + w_nacc[AW-1:0];
            r_rd_ptr   <= r_rd_ptr + AW'(w_pop) + w_ovw[AW-1:0];
            r_count    <= r_count - CW'(w_pop) + w_nacc - w_ovw;
            r_drop_cnt <= sat_add16(r_drop_cnt, w_drop_inc[1:0]);
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end
`endif

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (w_acc[k]) begin
                r_mem[r_wr_ptr + w_off[k]] <= w_entry[k];
            end
        end
    end

    // Head entry is read straight from storage
    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0);
    assign out_pc    = w_head.pc;
    assign out_wnum  = w_head.wnum;
    assign out_wdata = w_head.wdata;
    assign out_lane  = w_head.lane;
`ifdef TRACE_TIMESTAMP_EN
    assign out_ts    = w_head.ts;
`endif
    assign count     = r_count;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_debug_trace_buffer
// Drives two buffers (drop mode and overwrite mode, both four entries deep,
// two lanes) from the same stimulus and compares each against a queue-based
// reference model after every clock edge.
// ---------------------------------------------------------------------------
module tb_debug_trace_buffer;

    localparam int D = 4;

    logic        clk;
    logic        rst;
    logic [63:0] in_pc;
    logic [7:0]  in_wen;
    logic [9:0]  in_wnum;
    logic [63:0] in_wdata;
    logic        ready;

    logic        o0_valid, o1_valid;
    logic [31:0] o0_pc, o1_pc;
    logic [4:0]  o0_wnum, o1_wnum;
    logic [31:0] o0_wdata, o1_wdata;
    logic        o0_lane, o1_lane;
    logic [2:0]  o0_count, o1_count;
    logic [15:0] o0_drop, o1_drop;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] o0_ts, o1_ts;
`endif

    debug_trace_buffer #(.LANES(2), .DEPTH(D), .MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_pc(in_pc), .in_wen(in_wen), .in_wnum(in_wnum), .in_wdata(in_wdata),
        .out_valid(o0_valid), .out_ready(ready),
        .out_pc(o0_pc), .out_wnum(o0_wnum), .out_wdata(o0_wdata), .out_lane(o0_lane),
`ifdef TRACE_TIMESTAMP_EN
        .out_ts(o0_ts),
`endif
        .count(o0_count), .drop_cnt(o0_drop)
    );

    debug_trace_buffer #(.LANES(2), .DEPTH(D), .MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_pc(in_pc), .in_wen(in_wen), .in_wnum(in_wnum), .in_wdata(in_wdata),
        .out_valid(o1_valid), .out_ready(ready),
        .out_pc(o1_pc), .out_wnum(o1_wnum), .out_wdata(o1_wdata), .out_lane(o1_lane),
`ifdef TRACE_TIMESTAMP_EN
        .out_ts(o1_ts),
`endif
        .count(o1_count), .drop_cnt(o1_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        lane;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   md0, md1;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int k, input logic [31:0] pc, input logic [3:0] wen,
                            input logic [4:0] wnum, input logic [31:0] d);
        in_pc[32*k +: 32]   = pc;
        in_wen[4*k +: 4]    = wen;
        in_wnum[5*k +: 5]   = wnum;
        in_wdata[32*k +: 32] = d;
    endtask

    task automatic idle_lanes();
        set_lane(0, 32'h0, 4'h0, 5'd0, 32'h0);
        set_lane(1, 32'h0, 4'h0, 5'd0, 32'h0);
    endtask

    // Reference behaviour for one clock edge, from the inputs currently driven
    task automatic model_update();
        bit   pop0, pop1;
        ent_t e;
        pop0 = (q0.size() != 0) && ready;
        pop1 = (q1.size() != 0) && ready;
        if (pop0) void'(q0.pop_front());
        if (pop1) void'(q1.pop_front());
        for (int k = 0; k < 2; k++) begin
            if (in_wen[4*k +: 4] != 0 && in_wnum[5*k +: 5] != 0) begin
                e.pc    = in_pc[32*k +: 32];
                e.wnum  = in_wnum[5*k +: 5];
                e.wdata = in_wdata[32*k +: 32];
                e.lane  = 1'(k);
                if (q0.size() < D) q0.push_back(e);
                else if (md0 < 16'hFFFF) md0++;
                q1.push_back(e);
                if (q1.size() > D) begin
                    void'(q1.pop_front());
                    if (md1 < 16'hFFFF) md1++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("m0_valid", 32'(o0_valid), 32'(q0.size() != 0));
        chk("m0_count", 32'(o0_count), 32'(q0.size()));
        chk("m0_drop",  32'(o0_drop),  32'(md0));
        if (q0.size() != 0) begin
            chk("m0_pc",    o0_pc,           q0[0].pc);
            chk("m0_wnum",  32'(o0_wnum),    32'(q0[0].wnum));
            chk("m0_wdata", o0_wdata,        q0[0].wdata);
            chk("m0_lane",  32'(o0_lane),    32'(q0[0].lane));
        end
        chk("m1_valid", 32'(o1_valid), 32'(q1.size() != 0));
        chk("m1_count", 32'(o1_count), 32'(q1.size()));
        chk("m1_drop",  32'(o1_drop),  32'(md1));
        if (q1.size() != 0) begin
            chk("m1_pc",    o1_pc,           q1[0].pc);
            chk("m1_wnum",  32'(o1_wnum),    32'(q1[0].wnum));
            chk("m1_wdata", o1_wdata,        q1[0].wdata);
            chk("m1_lane",  32'(o1_lane),    32'(q1[0].lane));
        end
    endtask

    task automatic cycle(input bit do_chk);
        model_update();
        @(posedge clk);
        #1;
        if (do_chk) check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        md0 = 0;
        md1 = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        ready = 1'b0;
        idle_lanes();
        md0 = 0;
        md1 = 0;
        @(posedge clk);
        #1;
        // Reset state
        chk("rst_valid", 32'(o0_valid), 32'd0);
        chk("rst_count", 32'(o1_count), 32'd0);
        chk("rst_drop",  32'(o0_drop),  32'd0);
        rst = 1'b1;

        // Single push on lane 0
        set_lane(0, 32'hBFC00000, 4'hF, 5'd3, 32'h1234);
        cycle(1);
        chk("single_valid", 32'(o0_valid), 32'd1);
        chk("single_wnum",  32'(o0_wnum),  32'd3);
        chk("single_count", 32'(o0_count), 32'd1);

        // Drain it
        idle_lanes();
        ready = 1'b1;
        cycle(1);

        // Filtered events: zero destination and zero enables
        set_lane(0, 32'h200, 4'hF, 5'd0, 32'hAAAA);
        set_lane(1, 32'h204, 4'h0, 5'd7, 32'hBBBB);
        cycle(1);
        chk("filter_count", 32'(o0_count), 32'd0);
        chk("filter_drop",  32'(o1_drop),  32'd0);

        // Dual push, lane 0 then lane 1
        set_lane(0, 32'h100, 4'h3, 5'd1, 32'h11);
        set_lane(1, 32'h104, 4'hC, 5'd2, 32'h22);
        cycle(1);
        chk("dual_first_pc",   o0_pc,           32'h100);
        chk("dual_first_lane", 32'(o0_lane),    32'd0);
        idle_lanes();
        cycle(1);
        chk("dual_second_pc",   o0_pc,        32'h104);
        chk("dual_second_lane", 32'(o0_lane), 32'd1);
        cycle(1);

        // Fill to full, then push two with a pop in the same cycle
        do_reset();
        ready = 1'b0;
        set_lane(0, 32'h10, 4'hF, 5'd1, 32'hA0);
        set_lane(1, 32'h14, 4'hF, 5'd2, 32'hA1);
        cycle(1);
        set_lane(0, 32'h18, 4'hF, 5'd3, 32'hA2);
        set_lane(1, 32'h1C, 4'hF, 5'd4, 32'hA3);
        cycle(1);
        ready = 1'b1;
        set_lane(0, 32'h20, 4'hF, 5'd5, 32'hA4);
        set_lane(1, 32'h24, 4'hF, 5'd6, 32'hA5);
        cycle(1);
        chk("m0_full_count", 32'(o0_count), 32'd4);
        chk("m0_full_drop",  32'(o0_drop),  32'd1);

        // Overwrite of the two oldest with no pop
        do_reset();
        ready = 1'b0;
        set_lane(0, 32'h10, 4'hF, 5'd1, 32'hA0);
        set_lane(1, 32'h14, 4'hF, 5'd2, 32'hA1);
        cycle(1);
        set_lane(0, 32'h18, 4'hF, 5'd3, 32'hA2);
        set_lane(1, 32'h1C, 4'hF, 5'd4, 32'hA3);
        cycle(1);
        set_lane(0, 32'h20, 4'hF, 5'd5, 32'hA4);
        set_lane(1, 32'h24, 4'hF, 5'd6, 32'hA5);
        cycle(1);
        chk("m1_ovw_count", 32'(o1_count), 32'd4);
        chk("m1_ovw_drop",  32'(o1_drop),  32'd2);
        chk("m1_ovw_head",  o1_pc,         32'h18);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                set_lane(k, $urandom,
                         ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                         ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                         $urandom);
            end
            ready = 1'($urandom_range(0, 1));
            cycle(1);
        end

        // Drop counter saturation: two losses per cycle while full and stalled
        do_reset();
        ready = 1'b0;
        set_lane(0, 32'h300, 4'hF, 5'd9, 32'h5);
        set_lane(1, 32'h304, 4'hF, 5'd10, 32'h6);
        cycle(1);
        cycle(1);
        for (int i = 0; i < 32767; i++) cycle(0);
        check_all();
        chk("sat_pre",  32'(o0_drop), 32'hFFFE);
        cycle(1);
        chk("sat_hit",  32'(o1_drop), 32'hFFFF);
        cycle(1);
        chk("sat_hold", 32'(o0_drop), 32'hFFFF);

        // Asynchronous reset mid-stream at count 3
        do_reset();
        ready = 1'b0;
        set_lane(0, 32'h400, 4'hF, 5'd1, 32'h1);
        set_lane(1, 32'h404, 4'hF, 5'd2, 32'h2);
        cycle(1);
        set_lane(1, 32'h0, 4'h0, 5'd0, 32'h0);
        set_lane(0, 32'h408, 4'hF, 5'd3, 32'h3);
        cycle(1);
        chk("pre_rst_count", 32'(o0_count), 32'd3);
        idle_lanes();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid0", 32'(o0_valid), 32'd0);
        chk("arst_count0", 32'(o0_count), 32'd0);
        chk("arst_drop0",  32'(o0_drop),  32'd0);
        chk("arst_valid1", 32'(o1_valid), 32'd0);
        chk("arst_count1", 32'(o1_count), 32'd0);
        q0.delete();
        q1.delete();
        md0 = 0;
        md1 = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
